// File: rtl/zdisp_pkg.sv
// Shared state encoding and default parameters for the display frame task scheduler.
package zdisp_pkg;

    typedef enum logic [2:0] {
        ST_INIT       = 3'd0,
        ST_WAIT_FRAME = 3'd1,
        ST_ISSUE      = 3'd2,
        ST_NEXT       = 3'd3,
        ST_FINISH     = 3'd4
    } sched_state_e;

    localparam int DEF_NUM_TASKS    = 4;
    localparam int DEF_TRIG_W       = 4;
    localparam int DEF_INIT_CODE    = 1;
    localparam int DEF_TASK_BASE    = 2;
    localparam int DEF_TIMER_PERIOD = 1_333_333;
    localparam int DEF_TIMEOUT      = 16_000_000;
    localparam int DEF_CNT_W        = 24;

    // Task index width: covers 0..15, so the index can reach NUM_TASKS itself.
    localparam int IDX_W = 4;

endpackage

// File: rtl/frame_task_scheduler_frame_tick_gen.sv
// Frame-start event generator: free-running frame timer, sync rising-edge detector
// and the mode select that picks between them.
module frame_tick_gen
    import zdisp_pkg::*;
#(
    parameter int TIMER_PERIOD = DEF_TIMER_PERIOD,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    input  logic mode_ext,
    input  logic mode_ld,
    output logic start_ev
);

    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TIMER_PERIOD - 1);

    logic [CNT_W-1:0] timer_cnt_r;
    logic             sync_d_r;
    logic             mode_r;
    logic             tick_s;
    logic             sync_rise_s;
    logic             mode_sel_s;

    assign tick_s      = (timer_cnt_r == TICK_LAST);
    assign sync_rise_s = sync_in & ~sync_d_r;
    // While idle the live mode input applies at once; mid-frame the held value is used.
    assign mode_sel_s  = mode_ld ? mode_ext : mode_r;
    assign start_ev    = mode_sel_s ? sync_rise_s : tick_s;

    // Timer, sync history and held mode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer_cnt_r <= {CNT_W{1'b0}};
            sync_d_r    <= 1'b0;
            mode_r      <= 1'b0;
        end else begin
            timer_cnt_r <= tick_s ? {CNT_W{1'b0}} : timer_cnt_r + CNT_W'(1);
            sync_d_r    <= sync_in;
            mode_r      <= mode_sel_s;
        end
    end

endmodule

// File: rtl/frame_task_scheduler.sv
// Frame task scheduler: runs a one-time init task, then on every frame start issues the
// enabled draw tasks to the display adapter one at a time via an en_task/done handshake.
module frame_task_scheduler
    import zdisp_pkg::*;
#(
    parameter int NUM_TASKS    = DEF_NUM_TASKS,
    parameter int TRIG_W       = DEF_TRIG_W,
    parameter int INIT_CODE    = DEF_INIT_CODE,
    parameter int TASK_BASE    = DEF_TASK_BASE,
    parameter int TIMER_PERIOD = DEF_TIMER_PERIOD,
    parameter int TIMEOUT      = DEF_TIMEOUT,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sync_in,
    input  logic                 mode_ext,
    input  logic [NUM_TASKS-1:0] task_mask,
    input  logic                 done,
    output logic                 en_task,
    output logic [TRIG_W-1:0]    trigger,
    output logic                 busy,
    output logic [15:0]          frame_cnt,
    output logic [CNT_W-1:0]     frame_cycles,
    output logic                 overrun,
    output logic                 timeout_err
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0] IDX_END  = IDX_W'(NUM_TASKS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    sched_state_e     state_r;
    sched_state_e     state_nxt_s;
    logic [IDX_W-1:0] idx_r;
    logic [IDX_W-1:0] idx_nxt_s;
    logic [IDX_W-1:0] idx_inc_s;
    logic [15:0]      mask_pad_s;
    logic             pending_r;
    logic [CNT_W-1:0] task_cnt_r;
    logic [CNT_W-1:0] cyc_r;
    logic             start_ev_s;
    logic             hs_s;
    logic             tmo_s;
    logic             in_frame_s;
    logic             req_nxt_s;
    logic [TRIG_W-1:0] trig_nxt_s;

    assign mask_pad_s = 16'(task_mask);
    assign idx_inc_s  = idx_r + IDX_W'(1);
    assign hs_s       = en_task & done;
    assign tmo_s      = en_task & ~done & (task_cnt_r == TMO_LAST);
    assign in_frame_s = (state_r == ST_ISSUE) || (state_r == ST_NEXT) || (state_r == ST_FINISH);

    frame_tick_gen #(
        .TIMER_PERIOD (TIMER_PERIOD),
        .CNT_W        (CNT_W)
    ) u_tick (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_in  (sync_in),
        .mode_ext (mode_ext),
        .mode_ld  (state_r == ST_WAIT_FRAME),
        .start_ev (start_ev_s)
    );

    // State register plus registered handshake and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_INIT;
            idx_r       <= {IDX_W{1'b0}};
            en_task     <= 1'b0;
            trigger     <= {TRIG_W{1'b0}};
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            idx_r       <= idx_nxt_s;
            en_task     <= req_nxt_s;
            trigger     <= trig_nxt_s;
            busy        <= (state_nxt_s == ST_ISSUE) || (state_nxt_s == ST_NEXT);
            overrun     <= start_ev_s & in_frame_s;
            timeout_err <= tmo_s;
        end
    end

    // Next-state and task index selection.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            ST_INIT: begin
                if (hs_s || tmo_s) begin
                    state_nxt_s = ST_WAIT_FRAME;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_WAIT_FRAME: begin
                if (start_ev_s || pending_r) begin
                    state_nxt_s = ST_ISSUE;
                    idx_nxt_s   = {IDX_W{1'b0}};
                end else begin
                    state_nxt_s = ST_WAIT_FRAME;
                end
            end
            ST_ISSUE: begin
                if (!mask_pad_s[idx_r] || hs_s || tmo_s) begin
                    state_nxt_s = ST_NEXT;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_NEXT: begin
                idx_nxt_s = idx_inc_s;
                if (idx_inc_s == IDX_END) begin
                    state_nxt_s = ST_FINISH;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_FINISH: begin
                state_nxt_s = ST_WAIT_FRAME;
            end
            default: begin
                state_nxt_s = ST_INIT;
                idx_nxt_s   = {IDX_W{1'b0}};
            end
        endcase
    end

    // Request and trigger code are derived from the upcoming state so they are registered.
    always_comb begin
        req_nxt_s  = 1'b0;
        trig_nxt_s = {TRIG_W{1'b0}};
        case (state_nxt_s)
            ST_INIT: begin
                req_nxt_s  = 1'b1;
                trig_nxt_s = TRIG_W'(INIT_CODE);
            end
            ST_ISSUE: begin
                if (mask_pad_s[idx_nxt_s]) begin
                    req_nxt_s  = 1'b1;
                    trig_nxt_s = TRIG_W'(TASK_BASE) + TRIG_W'(idx_nxt_s);
                end else begin
                    req_nxt_s  = 1'b0;
                    trig_nxt_s = {TRIG_W{1'b0}};
                end
            end
            default: begin
                req_nxt_s  = 1'b0;
                trig_nxt_s = {TRIG_W{1'b0}};
            end
        endcase
    end

    // Single pending start: captured outside WAIT_FRAME, consumed when a frame starts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r <= 1'b0;
        end else if (state_r == ST_WAIT_FRAME) begin
            pending_r <= 1'b0;
        end else if (start_ev_s) begin
            pending_r <= 1'b1;
        end else begin
            pending_r <= pending_r;
        end
    end

    // Per-task handshake age, restarted whenever no request is outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            task_cnt_r <= {CNT_W{1'b0}};
        end else if (en_task && !done) begin
            task_cnt_r <= task_cnt_r + CNT_W'(1);
        end else begin
            task_cnt_r <= {CNT_W{1'b0}};
        end
    end

    // Frame duration and frame count; the starting edge and FINISH both count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_r        <= {CNT_W{1'b0}};
            frame_cycles <= {CNT_W{1'b0}};
            frame_cnt    <= 16'd0;
        end else begin
            case (state_r)
                ST_WAIT_FRAME: begin
                    cyc_r <= CNT_W'(1);
                end
                ST_ISSUE, ST_NEXT: begin
                    cyc_r <= sat_inc(cyc_r);
                end
                ST_FINISH: begin
                    frame_cycles <= sat_inc(cyc_r);
                    frame_cnt    <= frame_cnt + 16'd1;
                end
                default: begin
                    cyc_r <= cyc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_task_scheduler.sv
// Directed bench for frame_task_scheduler with short timer period and timeout.
module tb_frame_task_scheduler;

    logic        clk;
    logic        rst_n;
    logic        sync_in;
    logic        mode_ext;
    logic [3:0]  task_mask;
    logic        done;
    logic        en_task;
    logic [3:0]  trigger;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [23:0] frame_cycles;
    logic        overrun;
    logic        timeout_err;

    int checks   = 0;
    int failures = 0;

    int sync_offs[$];
    int log_trig[$];
    int log_t[$];
    int ovr_t[$];
    int tmo_t[$];
    int inc_t[$];
    int done_delay   = 3;
    int no_done_trig = 0;
    int frames_seen  = 0;

    frame_task_scheduler #(
        .NUM_TASKS    (4),
        .TRIG_W       (4),
        .INIT_CODE    (1),
        .TASK_BASE    (2),
        .TIMER_PERIOD (100),
        .TIMEOUT      (50),
        .CNT_W        (24)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .sync_in      (sync_in),
        .mode_ext     (mode_ext),
        .task_mask    (task_mask),
        .done         (done),
        .en_task      (en_task),
        .trigger      (trigger),
        .busy         (busy),
        .frame_cnt    (frame_cnt),
        .frame_cycles (frame_cycles),
        .overrun      (overrun),
        .timeout_err  (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Adapter model: answers each request after done_delay cycles and records events by cycle index.
    task automatic run_frames(input int nframes, input int budget);
        int          age;
        logic        prev_en;
        logic [15:0] last_fc;
        bit          hit;
        age = 0;
        prev_en = en_task;
        last_fc = frame_cnt;
        frames_seen = 0;
        log_trig.delete(); log_t.delete(); ovr_t.delete(); tmo_t.delete(); inc_t.delete();
        for (int i = 0; i < budget && frames_seen < nframes; i++) begin
            hit = 1'b0;
            foreach (sync_offs[j]) if (sync_offs[j] == i) hit = 1'b1;
            sync_in = hit;
            @(posedge clk); #1;
            if (en_task && !prev_en) begin
                log_trig.push_back(int'(trigger));
                log_t.push_back(i);
            end
            if (en_task) age++; else age = 0;
            done = en_task && (done_delay != 0) && (age == done_delay) && (int'(trigger) != no_done_trig);
            prev_en = en_task;
            if (overrun) ovr_t.push_back(i);
            if (timeout_err) tmo_t.push_back(i);
            if (frame_cnt != last_fc) begin
                inc_t.push_back(i);
                last_fc = frame_cnt;
                frames_seen++;
            end
        end
        sync_in = 1'b0;
        done = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sync_in = 1'b0; mode_ext = 1'b1; task_mask = 4'b1111; done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({en_task, trigger, busy, frame_cnt, frame_cycles, overrun, timeout_err} !== 48'd0) begin
            failures++;
            $display("FAIL reset_outputs got en=%0b trig=%0d busy=%0b fc=%0d exp all 0", en_task, trigger, busy, frame_cnt);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk); #1;
            checks++;
            if (en_task !== 1'b1 || trigger !== 4'd1) begin
                failures++;
                $display("FAIL init_request cycle %0d got en=%0b trig=%0d exp en=1 trig=1", c, en_task, trigger);
            end
        end
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        checks++;
        if (en_task !== 1'b0 || trigger !== 4'd0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL init_done got en=%0b trig=%0d busy=%0b fc=%0d exp 0 0 0 0", en_task, trigger, busy, frame_cnt);
        end
        done = 1'b1;
        @(posedge clk); #1;
        done = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (en_task !== 1'b0 || busy !== 1'b0 || frame_cnt !== 16'd0) begin
            failures++;
            $display("FAIL idle_done_ignored got en=%0b busy=%0b fc=%0d exp 0 0 0", en_task, busy, frame_cnt);
        end
    endtask

    task automatic test_timer_frames();
        mode_ext = 1'b0; task_mask = 4'b1111; done_delay = 3;
        sync_offs.delete();
        run_frames(3, 400);
        checks++;
        if (inc_t.size() !== 3) begin
            failures++;
            $display("FAIL timer_frame_count got %0d exp 3", inc_t.size());
        end else begin
            checks++;
            if (inc_t[1] - inc_t[0] !== 100 || inc_t[2] - inc_t[1] !== 100) begin
                failures++;
                $display("FAIL timer_period got %0d,%0d exp 100,100", inc_t[1] - inc_t[0], inc_t[2] - inc_t[1]);
            end
        end
        checks++;
        if (log_trig.size() !== 12) begin
            failures++;
            $display("FAIL timer_trigger_count got %0d exp 12", log_trig.size());
        end else begin
            for (int k = 0; k < 12; k++) begin
                checks++;
                if (log_trig[k] !== 2 + (k % 4)) begin
                    failures++;
                    $display("FAIL timer_trigger[%0d] got %0d exp %0d", k, log_trig[k], 2 + (k % 4));
                end
            end
        end
        checks++;
        if (frame_cycles !== 24'd18 || frame_cnt !== 16'd3) begin
            failures++;
            $display("FAIL timer_stats got cycles=%0d cnt=%0d exp 18 3", frame_cycles, frame_cnt);
        end
        mode_ext = 1'b1;
    endtask

    task automatic test_mask();
        task_mask = 4'b0101;
        sync_offs = '{0};
        run_frames(1, 60);
        checks++;
        if (log_trig.size() !== 2) begin
            failures++;
            $display("FAIL mask0101_count got %0d exp 2", log_trig.size());
        end else begin
            checks++;
            if (log_trig[0] !== 2 || log_trig[1] !== 4) begin
                failures++;
                $display("FAIL mask0101_triggers got %0d,%0d exp 2,4", log_trig[0], log_trig[1]);
            end
        end
        checks++;
        if (frame_cycles !== 24'd14) begin
            failures++;
            $display("FAIL mask0101_cycles got %0d exp 14", frame_cycles);
        end
        task_mask = 4'b0000;
        run_frames(1, 60);
        checks++;
        if (log_trig.size() !== 0 || inc_t.size() !== 1) begin
            failures++;
            $display("FAIL mask0_activity got reqs=%0d frames=%0d exp 0 1", log_trig.size(), inc_t.size());
        end else begin
            checks++;
            if (inc_t[0] !== 9) begin
                failures++;
                $display("FAIL mask0_latency got %0d exp 9", inc_t[0]);
            end
        end
        checks++;
        if (frame_cycles !== 24'd10 || frame_cnt !== 16'd5) begin
            failures++;
            $display("FAIL mask0_stats got cycles=%0d cnt=%0d exp 10 5", frame_cycles, frame_cnt);
        end
        task_mask = 4'b1111;
    endtask

    task automatic test_back_to_back();
        sync_offs = '{0, 9, 12};
        run_frames(3, 80);
        checks++;
        if (ovr_t.size() < 1) begin
            failures++;
            $display("FAIL overrun_pulse got none exp at cycle 9");
        end else begin
            checks++;
            if (ovr_t[0] !== 9) begin
                failures++;
                $display("FAIL overrun_cycle got %0d exp 9", ovr_t[0]);
            end
        end
        checks++;
        if (inc_t.size() !== 2) begin
            failures++;
            $display("FAIL pending_frames got %0d exp 2", inc_t.size());
        end else begin
            checks++;
            if (inc_t[0] !== 17 || inc_t[1] !== 35) begin
                failures++;
                $display("FAIL pending_frame_ends got %0d,%0d exp 17,35", inc_t[0], inc_t[1]);
            end
        end
        checks++;
        if (log_t.size() !== 8) begin
            failures++;
            $display("FAIL pending_requests got %0d exp 8", log_t.size());
        end else begin
            checks++;
            if (log_t[4] !== 18) begin
                failures++;
                $display("FAIL pending_restart got %0d exp 18", log_t[4]);
            end
        end
    endtask

    task automatic test_timeout();
        no_done_trig = 3;
        sync_offs = '{0};
        run_frames(1, 120);
        no_done_trig = 0;
        checks++;
        if (tmo_t.size() !== 1) begin
            failures++;
            $display("FAIL timeout_pulses got %0d exp 1", tmo_t.size());
        end else begin
            checks++;
            if (tmo_t[0] !== 54) begin
                failures++;
                $display("FAIL timeout_cycle got %0d exp 54", tmo_t[0]);
            end
        end
        checks++;
        if (log_trig.size() !== 4) begin
            failures++;
            $display("FAIL timeout_requests got %0d exp 4", log_trig.size());
        end else begin
            checks++;
            if (log_trig[2] !== 4 || log_t[2] !== 55) begin
                failures++;
                $display("FAIL timeout_advance got trig=%0d at %0d exp 4 at 55", log_trig[2], log_t[2]);
            end
        end
        checks++;
        if (frame_cycles !== 24'd65) begin
            failures++;
            $display("FAIL timeout_cycles got %0d exp 65", frame_cycles);
        end
    endtask

    task automatic test_reset_mid_task();
        sync_offs = '{0};
        run_frames(5, 13);
        checks++;
        if (en_task !== 1'b1 || trigger !== 4'd5) begin
            failures++;
            $display("FAIL mid_task_setup got en=%0b trig=%0d exp 1 5", en_task, trigger);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({en_task, trigger, busy, frame_cnt, frame_cycles, overrun, timeout_err} !== 48'd0) begin
            failures++;
            $display("FAIL async_reset got en=%0b trig=%0d busy=%0b fc=%0d cyc=%0d exp all 0", en_task, trigger, busy, frame_cnt, frame_cycles);
        end
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (en_task !== 1'b1 || trigger !== 4'd1) begin
            failures++;
            $display("FAIL reinit got en=%0b trig=%0d exp 1 1", en_task, trigger);
        end
    endtask

    initial begin
        test_reset();
        test_timer_frames();
        test_mask();
        test_back_to_back();
        test_timeout();
        test_reset_mid_task();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
